// File: rtl/pos_report_tx.sv
// pos_report_tx: mirrors the positioner step count and reports status
// frames over an 8N1 UART line. Optional macro: POS_REPORT_CKSUM_EN.
module pos_report_tx #(
    parameter int CLK_DIV = 434
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        step_tick,
    input  logic        m_en,
    input  logic        dir,
    input  logic        homed,
    input  logic        req,
    output logic        txd,
    output logic        busy,
    output logic [10:0] pos
);

    localparam logic [15:0] DIV_M1 = 16'(CLK_DIV - 1);
    localparam logic [7:0]  SYNC   = 8'hA5;
`ifdef POS_REPORT_CKSUM_EN
    localparam logic [1:0]  LAST_BYTE = 2'd3;
`else
    localparam logic [1:0]  LAST_BYTE = 2'd2;
`endif

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t      state_q;
    logic [10:0] pos_q, pos_d;
    logic        m_en_q, dir_q, req_q, pending_q;
    logic [13:0] last_sent_q, snap_q, status_w;
    logic [15:0] cnt_q;
    logic [2:0]  bit_q, bit_nx;
    logic [1:0]  byte_q;
    logic        txd_q, busy_q;
    logic [7:0]  b1_w, b2_w, cur_byte;

    assign status_w = {homed, m_en_q, dir_q, pos_q};
    assign b1_w     = {snap_q[13:11], 2'b00, snap_q[10:8]};
    assign b2_w     = snap_q[7:0];
    assign bit_nx   = bit_q + 3'd1;
    assign txd      = txd_q;
    assign busy     = busy_q;
    assign pos      = pos_q;

    // Next position: cleared while unhomed, saturating step otherwise.
    always_comb begin
        pos_d = pos_q;
        if (!homed) begin
            pos_d = '0;
        end else if (step_tick && m_en) begin
            if (!dir) begin
                if (pos_q != 11'h7FF) pos_d = pos_q + 11'd1;
            end else begin
                if (pos_q != 11'h000) pos_d = pos_q - 11'd1;
            end
        end
    end

    // Byte currently on the wire, selected from the frozen snapshot.
    always_comb begin
        case (byte_q)
            2'd0:    cur_byte = SYNC;
            2'd1:    cur_byte = b1_w;
            2'd2:    cur_byte = b2_w;
`ifdef POS_REPORT_CKSUM_EN
            default: cur_byte = SYNC ^ b1_w ^ b2_w;
`else
            default: cur_byte = 8'hFF;
`endif
        endcase
    end

    // Position mirror and status bits latched on each step tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            pos_q  <= '0;
            m_en_q <= 1'b0;
            dir_q  <= 1'b0;
        end else begin
            pos_q <= pos_d;
            if (step_tick) begin
                m_en_q <= m_en;
                dir_q  <= dir;
            end
        end
    end

    // Trigger tracking and UART framing state machine.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            req_q       <= 1'b0;
            pending_q   <= 1'b0;
            last_sent_q <= '0;
            snap_q      <= '0;
            cnt_q       <= '0;
            bit_q       <= '0;
            byte_q      <= '0;
            txd_q       <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            req_q <= req;
            if (status_w != last_sent_q || req_q) pending_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (pending_q) begin
                        state_q     <= START;
                        txd_q       <= 1'b0;
                        busy_q      <= 1'b1;
                        cnt_q       <= DIV_M1;
                        bit_q       <= '0;
                        byte_q      <= '0;
                        snap_q      <= status_w;
                        last_sent_q <= status_w;
                        // Only a request still in flight survives the capture.
                        pending_q   <= req_q;
                    end
                end
                START: begin
                    if (cnt_q != 16'd0) begin
                        cnt_q <= cnt_q - 16'd1;
                    end else begin
                        state_q <= DATA;
                        cnt_q   <= DIV_M1;
                        bit_q   <= '0;
                        txd_q   <= cur_byte[0];
                    end
                end
                DATA: begin
                    if (cnt_q != 16'd0) begin
                        cnt_q <= cnt_q - 16'd1;
                    end else begin
                        cnt_q <= DIV_M1;
                        if (bit_q == 3'd7) begin
                            state_q <= STOP;
                            txd_q   <= 1'b1;
                        end else begin
                            bit_q <= bit_nx;
                            txd_q <= cur_byte[bit_nx];
                        end
                    end
                end
                STOP: begin
                    if (cnt_q != 16'd0) begin
                        cnt_q <= cnt_q - 16'd1;
                    end else if (byte_q == LAST_BYTE) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        txd_q   <= 1'b1;
                    end else begin
                        state_q <= START;
                        byte_q  <= byte_q + 2'd1;
                        cnt_q   <= DIV_M1;
                        txd_q   <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pos_report_tx.sv
// tb_pos_report_tx: directed checks of pos_report_tx at CLK_DIV=4,
// decoding txd frames with a background monitor.
module tb_pos_report_tx;

`ifdef POS_REPORT_CKSUM_EN
    localparam int NB = 4;
`else
    localparam int NB = 3;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        step_tick = 1'b0;
    logic        m_en = 1'b0;
    logic        dir = 1'b0;
    logic        homed = 1'b0;
    logic        req = 1'b0;
    logic        txd, busy;
    logic [10:0] pos;

    int errors = 0;
    int checks = 0;

    logic [31:0] fq[$];
    int ferr = 0;
    int min_gap = 999;
    int low_run = 0;
    bit seen_high = 0;
    logic prev_busy = 1'b0;

    pos_report_tx #(.CLK_DIV(4)) dut (
        .clk(clk), .rst(rst), .step_tick(step_tick), .m_en(m_en),
        .dir(dir), .homed(homed), .req(req), .txd(txd),
        .busy(busy), .pos(pos)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] expw(input logic [7:0] a,
                                         input logic [7:0] b,
                                         input logic [7:0] c);
        logic [7:0] d;
        d = (NB == 4) ? (a ^ b ^ c) : 8'h00;
        return {a, b, c, d};
    endfunction

    // Frame decoder: samples each bit at cycle 0 of its 4-cycle slot.
    initial begin
        logic [7:0]  by;
        logic [31:0] word;
        bit          abort;
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && txd === 1'b0) begin
                abort = 0;
                word  = '0;
                by    = '0;
                for (int k = 0; k < NB; k++) begin
                    if (!abort && k > 0) begin
                        repeat (4) @(negedge clk);
                        if (rst) abort = 1;
                        else if (txd !== 1'b0) ferr++;
                    end
                    for (int j = 0; j < 8; j++) begin
                        if (!abort) begin
                            repeat (4) @(negedge clk);
                            if (rst) abort = 1;
                            else by[j] = txd;
                        end
                    end
                    if (!abort) begin
                        repeat (4) @(negedge clk);
                        if (rst) abort = 1;
                        else if (txd !== 1'b1) ferr++;
                    end
                    word[31-8*k -: 8] = by;
                end
                if (!abort) fq.push_back(word);
            end
        end
    end

    // Idle-gap tracker between consecutive busy periods.
    initial forever begin
        @(negedge clk);
        if (busy === 1'b1 && prev_busy === 1'b0 && seen_high)
            if (low_run < min_gap) min_gap = low_run;
        if (busy === 1'b1) begin
            seen_high = 1;
            low_run = 0;
        end else begin
            low_run++;
        end
        prev_busy = busy;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(output bit ok);
        int quiet = 0;
        for (int i = 0; i < 20000 && quiet < 60; i++) begin
            cyc(1);
            if (busy !== 1'b0) quiet = 0;
            else quiet++;
        end
        ok = (quiet >= 60);
    endtask

    task automatic wait_busy(output bit ok);
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            if (busy === 1'b1) begin
                ok = 1;
                break;
            end
        end
    endtask

    function automatic logic [31:0] last_frame();
        if (fq.size() == 0) return 'x;
        return fq[fq.size()-1];
    endfunction

    task automatic test_reset();
        int bad = 0;
        rst = 1'b1;
        cyc(3);
        checks++;
        if (txd !== 1'b1) begin
            errors++; $display("FAIL rst_txd: got %b want 1", txd);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL rst_busy: got %b want 0", busy);
        end
        checks++;
        if (pos !== 11'd0) begin
            errors++; $display("FAIL rst_pos: got %0d want 0", pos);
        end
        rst = 1'b0;
        fq.delete();
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (txd !== 1'b1 || busy !== 1'b0) bad++;
        end
        cyc(1);
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL quiet_line: got %0d bad cycles want 0", bad);
        end
        checks++;
        if (fq.size() != 0) begin
            errors++; $display("FAIL quiet_frames: got %0d want 0", fq.size());
        end
    endtask

    task automatic test_count_up();
        bit ok;
        fq.delete();
        homed = 1'b1; m_en = 1'b1; dir = 1'b0;
        step_tick = 1'b1;
        cyc(3);
        step_tick = 1'b0;
        wait_idle(ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL up_idle: got timeout want idle");
        end
        checks++;
        if (pos !== 11'd3) begin
            errors++; $display("FAIL up_pos: got %0d want 3", pos);
        end
        checks++;
        if (fq.size() < 1) begin
            errors++; $display("FAIL up_nframes: got %0d want >=1", fq.size());
        end
        checks++;
        if (last_frame() !== expw(8'hA5, 8'hC0, 8'h03)) begin
            errors++;
            $display("FAIL up_frame: got %h want %h", last_frame(),
                     expw(8'hA5, 8'hC0, 8'h03));
        end
    endtask

    task automatic test_down_at_zero();
        bit ok;
        rst = 1'b1; homed = 1'b0; m_en = 1'b0; dir = 1'b0;
        cyc(2);
        rst = 1'b0;
        cyc(2);
        fq.delete();
        homed = 1'b1; m_en = 1'b1; dir = 1'b1; step_tick = 1'b1;
        cyc(1);
        step_tick = 1'b0;
        wait_idle(ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL dn_idle: got timeout want idle");
        end
        checks++;
        if (pos !== 11'd0) begin
            errors++; $display("FAIL dn_pos: got %0d want 0", pos);
        end
        checks++;
        if (fq.size() != 1) begin
            errors++; $display("FAIL dn_nframes: got %0d want 1", fq.size());
        end
        checks++;
        if (last_frame() !== expw(8'hA5, 8'hE0, 8'h00)) begin
            errors++;
            $display("FAIL dn_frame: got %h want %h", last_frame(),
                     expw(8'hA5, 8'hE0, 8'h00));
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        logic [31:0] f0, f1;
        fq.delete();
        seen_high = 0;
        min_gap = 999;
        dir = 1'b0; m_en = 1'b1;
        req = 1'b1;
        cyc(1);
        req = 1'b0;
        wait_busy(ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL b2b_start: got no busy want busy");
        end
        cyc(20);
        req = 1'b1;
        cyc(1);
        req = 1'b0;
        step_tick = 1'b1;
        cyc(1);
        step_tick = 1'b0;
        cyc(3);
        step_tick = 1'b1;
        cyc(1);
        step_tick = 1'b0;
        wait_idle(ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL b2b_idle: got timeout want idle");
        end
        checks++;
        if (fq.size() != 2) begin
            errors++; $display("FAIL b2b_nframes: got %0d want 2", fq.size());
        end
        f0 = (fq.size() > 0) ? fq[0] : 'x;
        f1 = (fq.size() > 1) ? fq[1] : 'x;
        checks++;
        if (f0 !== expw(8'hA5, 8'hE0, 8'h00)) begin
            errors++;
            $display("FAIL b2b_f0: got %h want %h", f0,
                     expw(8'hA5, 8'hE0, 8'h00));
        end
        checks++;
        if (f1 !== expw(8'hA5, 8'hC0, 8'h02)) begin
            errors++;
            $display("FAIL b2b_f1: got %h want %h", f1,
                     expw(8'hA5, 8'hC0, 8'h02));
        end
        checks++;
        if (min_gap < 1 || min_gap >= 999) begin
            errors++; $display("FAIL b2b_gap: got %0d want 1..998", min_gap);
        end
        checks++;
        if (pos !== 11'd2) begin
            errors++; $display("FAIL b2b_pos: got %0d want 2", pos);
        end
    endtask

    task automatic test_tick_with_req();
        bit ok;
        fq.delete();
        m_en = 1'b1; dir = 1'b0;
        step_tick = 1'b1; req = 1'b1;
        cyc(1);
        step_tick = 1'b0; req = 1'b0;
        wait_idle(ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL tr_idle: got timeout want idle");
        end
        checks++;
        if (pos !== 11'd3) begin
            errors++; $display("FAIL tr_pos: got %0d want 3", pos);
        end
        checks++;
        if (fq.size() != 1) begin
            errors++; $display("FAIL tr_nframes: got %0d want 1", fq.size());
        end
        checks++;
        if (last_frame() !== expw(8'hA5, 8'hC0, 8'h03)) begin
            errors++;
            $display("FAIL tr_frame: got %h want %h", last_frame(),
                     expw(8'hA5, 8'hC0, 8'h03));
        end
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        int bad = 0;
        fq.delete();
        req = 1'b1;
        cyc(1);
        req = 1'b0;
        wait_busy(ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL mr_start: got no busy want busy");
        end
        cyc(64);
        checks++;
        if (txd !== 1'b0) begin
            errors++; $display("FAIL mr_b1_bit5: got %b want 0", txd);
        end
        rst = 1'b1; homed = 1'b0;
        cyc(1);
        checks++;
        if (txd !== 1'b1) begin
            errors++; $display("FAIL mr_txd: got %b want 1", txd);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL mr_busy: got %b want 0", busy);
        end
        checks++;
        if (pos !== 11'd0) begin
            errors++; $display("FAIL mr_pos: got %0d want 0", pos);
        end
        rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (txd !== 1'b1 || busy !== 1'b0) bad++;
        end
        cyc(1);
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL mr_quiet: got %0d bad cycles want 0", bad);
        end
        checks++;
        if (fq.size() != 0) begin
            errors++; $display("FAIL mr_frames: got %0d want 0", fq.size());
        end
    endtask

    task automatic test_saturate();
        bit ok;
        fq.delete();
        homed = 1'b1; m_en = 1'b1; dir = 1'b0;
        step_tick = 1'b1;
        cyc(2050);
        step_tick = 1'b0;
        wait_idle(ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL sat_idle: got timeout want idle");
        end
        checks++;
        if (pos !== 11'd2047) begin
            errors++; $display("FAIL sat_pos: got %0d want 2047", pos);
        end
        checks++;
        if (last_frame() !== expw(8'hA5, 8'hC7, 8'hFF)) begin
            errors++;
            $display("FAIL sat_frame: got %h want %h", last_frame(),
                     expw(8'hA5, 8'hC7, 8'hFF));
        end
        step_tick = 1'b1;
        cyc(1);
        step_tick = 1'b0;
        cyc(1);
        checks++;
        if (pos !== 11'd2047) begin
            errors++; $display("FAIL sat_hold: got %0d want 2047", pos);
        end
        fq.delete();
        homed = 1'b0;
        cyc(1);
        checks++;
        if (pos !== 11'd0) begin
            errors++; $display("FAIL unhome_pos: got %0d want 0", pos);
        end
        wait_idle(ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL unhome_idle: got timeout want idle");
        end
        checks++;
        if (last_frame() !== expw(8'hA5, 8'h40, 8'h00)) begin
            errors++;
            $display("FAIL unhome_frame: got %h want %h", last_frame(),
                     expw(8'hA5, 8'h40, 8'h00));
        end
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_down_at_zero();
        test_back_to_back();
        test_tick_with_req();
        test_reset_mid_frame();
        test_saturate();
        checks++;
        if (ferr != 0) begin
            errors++; $display("FAIL framing: got %0d bad start/stop want 0", ferr);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
